// File: rtl/pipe_ex_ls.sv
// EX->LS pipeline register with a one-entry skid buffer.
// The registered ready output cuts the combinational path back to the EXU.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 4
`endif

module pipe_ex_ls (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_pause,
  input  logic                      i_flush,
  input  logic                      i_exu_valid,
  output logic                      o_exu_ready,
  output logic                      o_lsu_valid,
  input  logic                      i_lsu_ready,
  input  logic [`CPU_WIDTH-1:0]     i_exu_pc,
  input  logic [`CPU_WIDTH-1:0]     i_exu_exres,
  input  logic [`CPU_WIDTH-1:0]     i_exu_rs2,
  input  logic [`REG_ADDRW-1:0]     i_exu_rdid,
  input  logic                      i_exu_rdwen,
  input  logic [`LSU_OPT_WIDTH-1:0] i_exu_lsopt,
  output logic [`CPU_WIDTH-1:0]     o_lsu_pc,
  output logic [`CPU_WIDTH-1:0]     o_lsu_exres,
  output logic [`CPU_WIDTH-1:0]     o_lsu_rs2,
  output logic [`REG_ADDRW-1:0]     o_lsu_rdid,
  output logic                      o_lsu_rdwen,
  output logic [`LSU_OPT_WIDTH-1:0] o_lsu_lsopt
);

  // State bits are {s_v, m_v}, so the valid flags fall straight out of the state.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  typedef struct packed {
    logic [`CPU_WIDTH-1:0]     pc;
    logic [`CPU_WIDTH-1:0]     exres;
    logic [`CPU_WIDTH-1:0]     rs2;
    logic [`REG_ADDRW-1:0]     rdid;
    logic                      rdwen;
    logic [`LSU_OPT_WIDTH-1:0] lsopt;
  } beat_t;

  beat_t      in_beat;
  beat_t      main_q, main_d;
  beat_t      skid_q, skid_d;
  logic [1:0] state_q, state_d;
  logic       accept, deliver;

  assign in_beat = '{pc: i_exu_pc, exres: i_exu_exres, rs2: i_exu_rs2,
                     rdid: i_exu_rdid, rdwen: i_exu_rdwen, lsopt: i_exu_lsopt};

  assign o_exu_ready = ~state_q[1];
  assign o_lsu_valid = state_q[0];
  assign accept      = i_exu_valid & o_exu_ready & ~i_pause;
  assign deliver     = state_q[0] & i_lsu_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = FULL;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_lsu_pc    = main_q.pc;
  assign o_lsu_exres = main_q.exres;
  assign o_lsu_rs2   = main_q.rs2;
  assign o_lsu_rdid  = main_q.rdid;
  assign o_lsu_rdwen = main_q.rdwen;
  assign o_lsu_lsopt = main_q.lsopt;

endmodule
